// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue/writeback stage.
//   DATA_W     datapath width (matches the ALU operand width)
//   NREGS      register count
//   REG_IDX_W  register index width
//   OP_W       opcode / ALU mode-select width
//   OP_*       opcode encodings; 100-110 are reserved and pass through to the ALU
//   state_t    sequencing FSM states
package alu_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned NREGS     = 8;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned OP_W      = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR = 3'b011;
  localparam logic [OP_W-1:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file, r0 hard-wired to zero.
//   clk, rst_n         clock, asynchronous active-low clear of all registers
//   rs1_addr/rs1_data  combinational read port 1
//   rs2_addr/rs2_data  combinational read port 2
//   dbg_addr/dbg_data  combinational debug read port
//   we, wa, wd         synchronous write port; writes to r0 are dropped
module alu_regfile #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W,
  parameter int unsigned NREGS  = alu_pkg::NREGS,
  parameter int unsigned IDX_W  = alu_pkg::REG_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rs1_addr,
  input  logic [IDX_W-1:0]  rs2_addr,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : mem[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : mem[rs2_addr];
    dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
  end

endmodule

// File: rtl/alu_issue_wb.sv
// Issue/writeback sequencer around an external combinational ALU.
// One instruction at a time: IDLE -> EXEC -> WB for ALU ops, IDLE -> WB for LDI.
//   clk, rst_n                     clock, asynchronous active-low reset
//   instr_valid/instr_ready        instruction handshake (ready only in IDLE)
//   instr_op/rd/rs1/rs2/imm        instruction fields, sampled on the accept edge
//   D1, D2, MS                     registered ALU operands and mode select
//   ALU_out                        combinational ALU result, captured in EXEC
//   wb_valid/wb_rd/wb_data         one-cycle writeback strobe and payload
//   dbg_addr/dbg_data              combinational register file peek
module alu_issue_wb #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W,
  parameter int unsigned NREGS  = alu_pkg::NREGS,
  parameter int unsigned OP_W   = alu_pkg::OP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [OP_W-1:0]          instr_op,
  input  logic [$clog2(NREGS)-1:0] instr_rd,
  input  logic [$clog2(NREGS)-1:0] instr_rs1,
  input  logic [$clog2(NREGS)-1:0] instr_rs2,
  input  logic [DATA_W-1:0]        instr_imm,
  output logic [DATA_W-1:0]        D1,
  output logic [DATA_W-1:0]        D2,
  output logic [OP_W-1:0]          MS,
  input  logic [DATA_W-1:0]        ALU_out,
  output logic                     wb_valid,
  output logic [$clog2(NREGS)-1:0] wb_rd,
  output logic [DATA_W-1:0]        wb_data,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  import alu_pkg::*;

  localparam int unsigned IDX_W = $clog2(NREGS);

  state_t            state, next_state;
  logic [IDX_W-1:0]  rd_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              accept;
  logic              is_ldi;

  assign accept = instr_valid && instr_ready;
  assign is_ldi = (instr_op == OP_LDI);

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (instr_rs1),
    .rs2_addr (instr_rs2),
    .dbg_addr (dbg_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (dbg_data),
    .we       (state == WB),
    .wa       (rd_q),
    .wd       (result_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = is_ldi ? WB : EXEC;
      EXEC:    next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: writeback payload is presented straight from the holding registers
  always_comb begin
    instr_ready = (state == IDLE);
    wb_valid    = (state == WB);
    wb_rd       = rd_q;
    wb_data     = result_q;
  end

  // Operand/result registers; D1/D2/MS keep their last values outside EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D1       <= '0;
      D2       <= '0;
      MS       <= '0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        rd_q <= instr_rd;
        if (is_ldi) begin
          result_q <= instr_imm;
        end else begin
          D1 <= rs1_data;
          D2 <= rs2_data;
          MS <= instr_op;
        end
      end
      if (state == EXEC) result_q <= ALU_out;
    end
  end

endmodule
